ram_sync_clr: RTL
=================

Name: ram_sync_clr

Overview:
- Parametrised synchronous static RAM for arcade board-level RAM replacement: playfield, colour and scratch RAMs of any width and depth.
- Keeps the classic chip pin semantics: two chip selects, active-low write, active-low output enable.
- Adds a registered read, a defined read-during-write rule, and a hardware clear engine that fills the array after reset or on request.
- Sits between CPU/video address muxes and the data buses, as a drop-in for fixed-size RAM models.

Parameters:
- AW, 8, address width; DEPTH = 2**AW words.
- DW, 4, data word width.
- INIT_VAL, 0, DW-bit value written to every word by the clear engine.
- CLEAR_ON_RESET, 1: 1 = clear runs after reset; 0 = reset goes straight to IDLE and array contents are undefined.

Ports:
- clk  input  1  single clock; all state changes on posedge.
- reset_n  input  1  asynchronous, active-low reset.
- a  input  AW  word address.
- i  input  DW  write data.
- d  output  DW  read data; registered.
- cs1_n  input  1  chip select, active low.
- cs2  input  1  chip select, active high.
- w_n  input  1  write strobe, active low.
- oe_n  input  1  output enable, active low.
- clr  input  1  synchronous clear request; pulse or level.
- busy  output  1  high while the clear engine owns the array.
- perr  output  1  registered parity error; see Optional Feature.

Behaviour:
- Clock and reset: one clock, clk. Reset reset_n is asynchronous and active-low.
- Select: sel = !cs1_n && cs2.
- Reset values: q (read register) = 0; d = 0; perr = 0; ptr = 0. State = CLEAR with busy = 1 if CLEAR_ON_RESET = 1, else IDLE with busy = 0. Array contents are not reset.
- State machine, two states (IDLE, CLEAR):
  - CLEAR, every cycle: mem[ptr] <= INIT_VAL, then ptr <= ptr+1.
  - When ptr == DEPTH-1, that last word is written and the next state is IDLE with ptr = 0.
  - A full clear takes exactly DEPTH cycles.
  - busy = (state == CLEAR), decoded from the registered state.
  - IDLE with clr = 1 -> CLEAR next cycle with ptr = 0.
  - CLEAR with clr = 1 -> ptr restarts at 0 and the state stays CLEAR. A held clr keeps the engine restarting.
  - reset_n asserted mid-clear -> immediate return to reset values; the clear restarts from 0 on release.
- Write: in IDLE with sel && !w_n, mem[a] <= i on posedge. In CLEAR, external writes are dropped silently.
- Read:
  - In IDLE with sel, q <= mem[a]; one-cycle latency.
  - When a write and a read hit the same address in the same cycle, q returns the OLD data. The new data is visible one cycle later.
  - In IDLE with sel = 0, q holds its value.
  - In CLEAR, q <= 0.
- Output: d = oe_n ? 0 : q. oe_n is combinational gating only; no tristate, and it never affects q.
- w_n low with sel low: no write.
- Address wraps naturally at DEPTH; there is no out-of-range case.

Optional Feature:
- Macro: RAM_PARITY_EN.
- Defined:
  - Each word stores an extra even-parity bit, computed from i on write; the clear engine stores parity of INIT_VAL.
  - On each select read in IDLE, perr <= (stored parity != ^stored data), aligned with q.
  - perr holds when sel = 0 and clears to 0 during CLEAR and on reset.
  - Under the macro, the bench may corrupt a stored parity bit by hierarchical force to exercise perr.
- Not defined: no parity storage; perr is tied to 0.

Test Plan (AW=8, DW=4, INIT_VAL=4'h5, CLEAR_ON_RESET=1 unless stated):
- Reset release: busy high for exactly 256 cycles, then low. Reading addresses 0x00, 0x7F and 0xFF then returns 5, one cycle after the address.
- Write/read: write 0xA to 0x12, write 0x3 to 0x13. Reading 0x12 gives d = A the next cycle, and 0x13 gives 3. With oe_n = 1, d = 0 while q is unchanged.
- Read-during-write: mem[0x40] = 0x7; write 0xC to 0x40 with sel and read in the same cycle. d = 7 next cycle, then C the following cycle.
- Selects: cs1_n = 1, or cs2 = 0, with w_n = 0 writing 0xF to 0x20 leaves mem[0x20] unchanged (reads 5). With sel = 0, d holds its last value across address changes.
- Clear interactions:
  - clr pulse in IDLE: busy for 256 cycles.
  - clr pulsed again at cycle 100: busy extends to 356 cycles total.
  - A write to 0x30 during busy is dropped; 0x30 reads 5 afterward.
  - reset_n pulsed at cycle 50 of a clear: outputs go to reset values immediately, and the clear restarts to a full 256 cycles.
- CLEAR_ON_RESET=0: busy = 0 straight after reset, and a write then read of 0x01 = 0x9 succeeds with no wait. With RAM_PARITY_EN, a forced parity flip on 0x05 gives perr = 1 aligned with that read, and perr = 0 on a clean read.

Source files
------------

// File: rtl/ram_sync_clr.sv
// Synchronous RAM with classic chip-select pins, registered read and a fill-on-request clear engine.
// Define RAM_PARITY_EN to store an even-parity bit per word and report read parity errors on perr.
module ram_sync_clr #(
    parameter int unsigned   AW             = 8,
    parameter int unsigned   DW             = 4,
    parameter logic [DW-1:0] INIT_VAL       = '0,
    parameter bit            CLEAR_ON_RESET = 1'b1
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic [AW-1:0] a,
    input  logic [DW-1:0] i,
    output logic [DW-1:0] d,
    input  logic          cs1_n,
    input  logic          cs2,
    input  logic          w_n,
    input  logic          oe_n,
    input  logic          clr,
    output logic          busy,
    output logic          perr
);

    localparam int unsigned DEPTH = 2 ** AW;
`ifdef RAM_PARITY_EN
    localparam int unsigned MW = DW + 1;
    localparam logic [MW-1:0] InitWord = {^INIT_VAL, INIT_VAL};
`else
    localparam int unsigned MW = DW;
    localparam logic [MW-1:0] InitWord = INIT_VAL;
`endif

    typedef enum logic [0:0] {
        StIdle,
        StClear
    } state_e;

    localparam state_e RstState = CLEAR_ON_RESET ? StClear : StIdle;

    state_e        state_q, state_d;
    logic [AW-1:0] ptr_q, ptr_d;
    logic [DW-1:0] q_q, q_d;

    logic          sel;
    logic          mem_we;
    logic [AW-1:0] mem_waddr;
    logic [MW-1:0] mem_wdata;
    logic [MW-1:0] mem_rdata;
    logic [MW-1:0] ext_word;

    logic [MW-1:0] mem [DEPTH];

    assign sel = !cs1_n && cs2;

`ifdef RAM_PARITY_EN
    assign ext_word = {^i, i};
`else
    assign ext_word = i;
`endif

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= RstState;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    // Next state: clr always restarts the sweep from word 0
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        unique case (state_q)
            StIdle: begin
                if (clr) begin
                    state_d = StClear;
                    ptr_d   = '0;
                end
            end
            StClear: begin
                if (clr) begin
                    ptr_d = '0;
                end else if (&ptr_q) begin
                    state_d = StIdle;
                    ptr_d   = '0;
                end else begin
                    ptr_d = ptr_q + AW'(1);
                end
            end
            default: begin
                state_d = StIdle;
                ptr_d   = '0;
            end
        endcase
    end

    // Outputs: the clear engine owns the write port while busy
    always_comb begin
        busy      = (state_q == StClear);
        mem_we    = 1'b0;
        mem_waddr = a;
        mem_wdata = ext_word;
        if (busy) begin
            mem_we    = 1'b1;
            mem_waddr = ptr_q;
            mem_wdata = InitWord;
        end else if (sel && !w_n) begin
            mem_we = 1'b1;
        end
    end

    // Array is deliberately not reset
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    // Read samples the pre-write contents, so a same-address write returns old data
    assign mem_rdata = mem[a];

    always_comb begin
        q_d = q_q;
        if (busy) begin
            q_d = '0;
        end else if (sel) begin
            q_d = mem_rdata[DW-1:0];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign d = oe_n ? '0 : q_q;

`ifdef RAM_PARITY_EN
    logic perr_q, perr_d;

    always_comb begin
        perr_d = perr_q;
        if (busy) begin
            perr_d = 1'b0;
        end else if (sel) begin
            perr_d = mem_rdata[DW] != ^mem_rdata[DW-1:0];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            perr_q <= 1'b0;
        end else begin
            perr_q <= perr_d;
        end
    end

    assign perr = perr_q;
`else
    assign perr = 1'b0;
`endif

endmodule
